// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter slice.
// Arbiter state encoding and grant-index width helper.
package uart_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int MAX_NREQ = 8;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request
// at or above ptr, wrapping modulo NREQ.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [id_w(NREQ)-1:0]   ptr,
    output logic                    any,
    output logic [id_w(NREQ)-1:0]   idx
);

    localparam int IW = id_w(NREQ);

    int j;

    // Scan farthest-first so the nearest hit overwrites.
    always_comb begin
        any = |req;
        idx = '0;
        j   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (req[j]) idx = j[IW-1:0];
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Message-locking round-robin arbiter in front of the
// shared UART TX serializer.
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 64,
    parameter int IDLE_TMO  = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_vld,
    input  logic [NREQ*8-1:0]       req_ch,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_rdy,
    output logic                    tx_ch_vld,
    output logic [7:0]              tx_ch,
    input  logic                    tx_rdy,
    output logic                    grant_vld,
    output logic [id_w(NREQ)-1:0]   grant_id
);

    localparam int IW = id_w(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(IDLE_TMO + 1);

    arb_state_e      state, state_nxt;
    logic [IW-1:0]   owner, owner_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [BW-1:0]   burst_cnt, burst_nxt;
    logic [TW-1:0]   tmo_cnt, tmo_nxt;
    logic            pick_any;
    logic [IW-1:0]   pick_idx;
    logic            own_vld;
    logic            own_last;
    logic            hs;
    logic            rel;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req  (req_vld),
        .ptr  (ptr),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign own_vld  = req_vld[owner];
    assign own_last = req_last[owner];

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        burst_nxt = burst_cnt;
        tmo_nxt   = tmo_cnt;
        tx_ch_vld = 1'b0;
        tx_ch     = '0;
        req_rdy   = '0;
        hs        = 1'b0;
        rel       = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = LOCK;
                    owner_nxt = pick_idx;
                    burst_nxt = '0;
                    tmo_nxt   = '0;
                end
            end
            LOCK: begin
                tx_ch_vld      = own_vld;
                tx_ch          = req_ch[8*owner +: 8];
                req_rdy[owner] = tx_rdy;
                hs             = own_vld & tx_rdy;
                if (hs) burst_nxt = burst_cnt + 1'b1;
                tmo_nxt = own_vld ? '0 : tmo_cnt + 1'b1;
                // Limits are compared one short: release on the
                // cycle that would reach them.
                rel = (hs && (own_last ||
                       burst_cnt == BW'(MAX_BURST - 1))) ||
                      (!own_vld && tmo_cnt == TW'(IDLE_TMO - 1));
                if (rel) begin
                    state_nxt = IDLE;
                    ptr_nxt   = (owner == IW'(NREQ - 1)) ?
                                '0 : owner + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            ptr       <= '0;
            burst_cnt <= '0;
            tmo_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            ptr       <= ptr_nxt;
            burst_cnt <= burst_nxt;
            tmo_cnt   <= tmo_nxt;
        end
    end

    assign grant_vld = (state == LOCK);
    assign grant_id  = grant_vld ? owner : '0;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: vector tables plus
// hand sequences for arbitration, limits and reset.
module tb_uart_tx_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_vld;
    logic [31:0] req_ch;
    logic [3:0]  req_last;
    logic [3:0]  req_rdy;
    logic        tx_ch_vld;
    logic [7:0]  tx_ch;
    logic        tx_rdy;
    logic        grant_vld;
    logic [1:0]  grant_id;

    uart_tx_arb #(
        .NREQ      (4),
        .MAX_BURST (4),
        .IDLE_TMO  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_vld   (req_vld),
        .req_ch    (req_ch),
        .req_last  (req_last),
        .req_rdy   (req_rdy),
        .tx_ch_vld (tx_ch_vld),
        .tx_ch     (tx_ch),
        .tx_rdy    (tx_rdy),
        .grant_vld (grant_vld),
        .grant_id  (grant_id)
    );

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] ch;
        logic [3:0]  last;
        logic        rdy;
        logic [15:0] exp;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int nhs;

    vec_t tbl1[5];
    vec_t tbl2[8];

    int t_tot[4];
    int t_len[4];
    int t_ord[8];
    int t_cnt[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(
        input logic [3:0] vld, input logic [31:0] ch,
        input logic [3:0] last, input logic rdy,
        input logic gv, input logic [1:0] gid,
        input logic tv, input logic [7:0] tch,
        input logic [3:0] rr);
        vec_t v;
        v.vld  = vld;
        v.ch   = ch;
        v.last = last;
        v.rdy  = rdy;
        v.exp  = {gv, gid, tv, tch, rr};
        return v;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {grant_vld, grant_id, tx_ch_vld, tx_ch, req_rdy};
    endfunction

    task automatic drive(input logic [3:0] vld,
                         input logic [31:0] ch,
                         input logic [3:0] last,
                         input logic rdy);
        @(posedge clk);
        #1;
        req_vld  = vld;
        req_ch   = ch;
        req_last = last;
        tx_rdy   = rdy;
        @(negedge clk);
    endtask

    task automatic apply_vec(input string name, input vec_t v);
        drive(v.vld, v.ch, v.last, v.rdy);
        chk(name, {16'h0, outs()}, {16'h0, v.exp});
    endtask

    task automatic clear_in();
        req_vld  = '0;
        req_ch   = '0;
        req_last = '0;
        tx_rdy   = 1'b1;
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        #1;
        chk(name, {16'h0, outs()}, 32'h0);
        chk({name, "_ptr"}, {30'h0, dut.ptr}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_traffic(input string name, input int ngr);
        int  sent[4];
        bit  hsv[4];
        int  g;
        int  gbytes;
        bit  prev_gv;
        bit  done;
        g = 0;
        gbytes = 0;
        prev_gv = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sent[i] = 0;
            hsv[i]  = 1'b0;
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (hsv[i]) sent[i]++;
                hsv[i] = 1'b0;
                req_vld[i]  = (sent[i] < t_tot[i]);
                req_ch[8*i +: 8] = 8'(16 * i + sent[i]);
                req_last[i] = ((sent[i] + 1) % t_len[i] == 0) ||
                              (sent[i] + 1 == t_tot[i]);
            end
            tx_rdy = 1'b1;
            @(negedge clk);
            if (grant_vld && !prev_gv) begin
                if (g > 0)
                    chk({name, "_bytes"}, gbytes, t_cnt[g-1]);
                if (g < 8)
                    chk({name, "_order"}, {30'h0, grant_id},
                        t_ord[g]);
                g++;
                gbytes = 0;
            end
            for (int i = 0; i < 4; i++) begin
                if (req_vld[i] && req_rdy[i]) begin
                    hsv[i] = 1'b1;
                    gbytes++;
                    chk({name, "_byte"},
                        {22'h0, grant_id, tx_ch},
                        {22'h0, 2'(i), 8'(16 * i + sent[i])});
                end
            end
            prev_gv = grant_vld;
            done = 1'b1;
            for (int i = 0; i < 4; i++)
                if (sent[i] + int'(hsv[i]) < t_tot[i]) done = 1'b0;
            if (done && !grant_vld && cyc > 2) break;
        end
        if (g > 0)
            chk({name, "_bytes"}, gbytes, t_cnt[g-1]);
        chk({name, "_grants"}, g, ngr);
        chk({name, "_done"}, {31'h0, done}, 32'h1);
        clear_in();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_in();
        #1;
        chk("reset_state", {16'h0, outs()}, 32'h0);
        chk("reset_ptr", {30'h0, dut.ptr}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        tbl1[0] = mk(4'b0100, 32'h0068_0000, 4'b0000, 1,
                     0, 2'd0, 0, 8'h00, 4'b0000);
        tbl1[1] = mk(4'b0100, 32'h0068_0000, 4'b0000, 1,
                     1, 2'd2, 1, 8'h68, 4'b0100);
        tbl1[2] = mk(4'b0100, 32'h0069_0000, 4'b0000, 1,
                     1, 2'd2, 1, 8'h69, 4'b0100);
        tbl1[3] = mk(4'b0100, 32'h000A_0000, 4'b0100, 1,
                     1, 2'd2, 1, 8'h0A, 4'b0100);
        tbl1[4] = mk(4'b0000, 32'h0000_0000, 4'b0000, 1,
                     0, 2'd0, 0, 8'h00, 4'b0000);
        for (int i = 0; i < 5; i++)
            apply_vec($sformatf("single_%0d", i), tbl1[i]);
        chk("single_ptr", {30'h0, dut.ptr}, 32'd3);

        tbl2[0] = mk(4'b0010, 32'h0000_4100, 4'b0000, 1,
                     0, 2'd0, 0, 8'h00, 4'b0000);
        tbl2[1] = mk(4'b0011, 32'h0000_4130, 4'b0001, 1,
                     1, 2'd1, 1, 8'h41, 4'b0010);
        tbl2[2] = mk(4'b0011, 32'h0000_4230, 4'b0011, 0,
                     1, 2'd1, 1, 8'h42, 4'b0000);
        tbl2[3] = mk(4'b0011, 32'h0000_4230, 4'b0011, 0,
                     1, 2'd1, 1, 8'h42, 4'b0000);
        tbl2[4] = mk(4'b0011, 32'h0000_4230, 4'b0011, 1,
                     1, 2'd1, 1, 8'h42, 4'b0010);
        tbl2[5] = mk(4'b0001, 32'h0000_0030, 4'b0001, 1,
                     0, 2'd0, 0, 8'h00, 4'b0000);
        tbl2[6] = mk(4'b0001, 32'h0000_0030, 4'b0001, 1,
                     1, 2'd0, 1, 8'h30, 4'b0001);
        tbl2[7] = mk(4'b0000, 32'h0000_0000, 4'b0000, 1,
                     0, 2'd0, 0, 8'h00, 4'b0000);
        nhs = 0;
        for (int i = 0; i < 8; i++) begin
            apply_vec($sformatf("bp_%0d", i), tbl2[i]);
            if (req_vld[1] && req_rdy[1]) nhs++;
        end
        chk("bp_hs_count", nhs, 2);

        clear_in();
        do_reset("rr_reset");
        t_tot = '{4, 4, 0, 4};
        t_len = '{2, 2, 1, 2};
        t_ord = '{0, 1, 3, 0, 1, 3, 0, 0};
        t_cnt = '{2, 2, 2, 2, 2, 2, 0, 0};
        run_traffic("rr", 6);

        do_reset("burst_reset");
        t_tot = '{10, 1, 0, 0};
        t_len = '{10, 1, 1, 1};
        t_ord = '{0, 1, 0, 0, 0, 0, 0, 0};
        t_cnt = '{4, 1, 4, 2, 0, 0, 0, 0};
        run_traffic("burst", 4);

        do_reset("tmo_reset");
        drive(4'b0100, 32'h0055_0000, 4'b0000, 1);
        drive(4'b0100, 32'h0055_0000, 4'b0000, 1);
        chk("tmo_first", {16'h0, outs()},
            {16'h0, 1'b1, 2'd2, 1'b1, 8'h55, 4'b0100});
        repeat (5) drive(4'b0000, 32'h0, 4'b0000, 1);
        chk("tmo_gap", {30'h0, grant_vld, tx_ch_vld}, 32'h2);
        drive(4'b0100, 32'h0056_0000, 4'b0000, 1);
        chk("tmo_resume", {16'h0, outs()},
            {16'h0, 1'b1, 2'd2, 1'b1, 8'h56, 4'b0100});
        for (int k = 1; k <= 9; k++) begin
            drive(4'b0000, 32'h0, 4'b0000, 1);
            chk($sformatf("tmo_idle_%0d", k),
                {31'h0, grant_vld}, (k <= 8) ? 32'h1 : 32'h0);
        end

        drive(4'b0100, 32'h0061_0000, 4'b0000, 1);
        drive(4'b0100, 32'h0061_0000, 4'b0000, 1);
        chk("rst_byte1", {16'h0, outs()},
            {16'h0, 1'b1, 2'd2, 1'b1, 8'h61, 4'b0100});
        drive(4'b0101, 32'h0062_0070, 4'b0001, 1);
        do_reset("rst_mid");
        drive(4'b0101, 32'h0062_0070, 4'b0001, 1);
        chk("rst_winner", {16'h0, outs()},
            {16'h0, 1'b1, 2'd0, 1'b1, 8'h70, 4'b0001});
        drive(4'b0100, 32'h0062_0000, 4'b0000, 1);
        chk("rst_bubble", {31'h0, grant_vld}, 32'h0);
        drive(4'b0100, 32'h0062_0000, 4'b0000, 1);
        chk("rst_second", {16'h0, outs()},
            {16'h0, 1'b1, 2'd2, 1'b1, 8'h62, 4'b0100});

        clear_in();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares the SoC's single UART transmit serializer among several byte-stream requesters (e.g. CPU console port, debug monitor, DMA log). It locks the serializer to one requester for a whole message, so characters from different sources never interleave mid-line on `uart_tx`. It sits between the requesters and the existing UART TX serializer inside `soc`. It does not change baud or framing.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `MAX_BURST`, default 64: maximum bytes per grant before forced release.
- `IDLE_TMO`, default 255: consecutive owner-idle cycles before forced release.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_vld` in NREQ: per-requester byte valid.
- `req_ch` in NREQ*8: per-requester byte; requester i uses bits [8i+7:8i].
- `req_last` in NREQ: byte is the last of the message (qualified by the handshake).
- `req_rdy` out NREQ: per-requester byte accepted.
- `tx_ch_vld` out 1: byte valid to the serializer.
- `tx_ch` out 8: byte to the serializer.
- `tx_rdy` in 1: serializer can accept a byte this cycle.
- `grant_vld` out 1: a requester currently owns the serializer.
- `grant_id` out $clog2(NREQ): current owner index; 0 when `grant_vld`=0.

## Operation
- Two states: IDLE and LOCK.
- **IDLE**
  - `tx_ch_vld`=0 and all `req_rdy`=0.
  - If any `req_vld` is set, pick the first set bit searching upward from `ptr` and wrapping modulo NREQ.
  - Register the pick as `owner`, clear `burst_cnt` and `tmo_cnt`, then go to LOCK.
- **LOCK** (combinational passthrough for the owner only)
  - `tx_ch_vld` = `req_vld[owner]`, `tx_ch` = `req_ch[owner]`, `req_rdy[owner]` = `tx_rdy`.
  - `req_rdy` of every non-owner is 0.
  - The handshake (`hs`) is `req_vld[owner]` & `tx_rdy`. Each `hs` increments `burst_cnt`.
  - `tmo_cnt` increments on each cycle where `req_vld[owner]`=0 and clears on any cycle where `req_vld[owner]`=1.
- **Release** to IDLE, with `ptr` <= (`owner`+1) mod NREQ, on the first of these:
  - `hs` with `req_last[owner]`=1;
  - `hs` that makes `burst_cnt`==MAX_BURST;
  - `tmo_cnt` reaching IDLE_TMO.
- `ptr` resets to 0. Width rules:
  - `burst_cnt` is $clog2(MAX_BURST+1) bits.
  - `tmo_cnt` is $clog2(IDLE_TMO+1) bits.
  - Neither counter wraps, because release occurs at the limit.
- **Outputs at reset:**
  - `tx_ch_vld`=0, `tx_ch`=0, `req_rdy`=0.
  - `grant_vld`=0, `grant_id`=0.
  - State is IDLE; `owner`, `ptr` and the counters are 0.
- **Reset mid-message:** all of the above clear asynchronously. The in-flight byte is not transferred unless `hs` completed before the reset edge.
- **Requester rules:**
  - A requester holds `req_ch` and `req_last` stable while `req_vld`=1 and no `hs` has occurred.
  - Dropping `req_vld` between bytes is legal.

## Timing
- Arbitration latency: a request seen in IDLE at edge t gives `grant_vld`=1 after edge t+1. The first `hs` can occur in that same cycle.
- Passthrough from owner to serializer adds zero cycles.
- After a release there is one IDLE bubble cycle, even when other requests are pending. Sustained two-requester traffic therefore costs one bubble per message.
- Simultaneous requests: the winner is the nearest index at or above `ptr`. The loser is served at the next arbitration, unless a nearer index is requesting by then.
- **Fairness:** every continuously requesting source wins within NREQ grants.
- Forced release by MAX_BURST happens on the handshake cycle itself. The remaining bytes of that message re-arbitrate.
- `req_last` together with `burst_cnt` reaching MAX_BURST on the same `hs` causes a single release.

## Structure
- Package `uart_arb_pkg` holds:
  - `arb_state_e` (IDLE, LOCK);
  - a width helper constant for `grant_id`.
- Sub-module `rr_pick`: combinational, parameterized NREQ. Inputs are the request vector and `ptr`; outputs are `any` and `idx`. Reusable by other arbiters.
- The top level holds the FSM, counters, and the passthrough mux.

## Test plan
- **Single requester:** NREQ=4; req 2 sends "hi\n" with `req_last` on '\n' and `tx_rdy`=1 always.
  - Expect `grant_id`=2 one cycle after `req_vld`.
  - Expect 3 consecutive bytes 0x68, 0x69, 0x0A on `tx_ch`.
  - Expect `grant_vld`=0 the cycle after '\n'.
  - Expect `ptr`=3.
- **Round-robin:** reqs 0, 1 and 3 each send 2-byte messages continuously.
  - Expect grant order 0, 1, 3, 0, 1, 3.
  - Expect no byte interleaving across messages.
- **Backpressure:** owner 1 with `tx_rdy` toggling 1,0,0,1.
  - `req_rdy[1]` follows `tx_rdy` exactly.
  - `tx_ch` holds its value while stalled.
  - Expect exactly 2 handshakes.
- **Burst and timeout limits:**
  - MAX_BURST=4: 10-byte message from req 0 while req 1 waits. Expect release after byte 4, then req 1 is granted, then req 0 resumes.
  - IDLE_TMO=8: owner drops `req_vld` for 8 cycles. Expect release on cycle 8.
- **Reset mid-message:** assert `rst_n`=0 while owner 2 has sent 1 of 3 bytes.
  - All outputs go to 0 immediately.
  - After release, req 0 and req 2 pending simultaneously: expect req 0 is granted first (`ptr`=0).
